pipelined_block_adder: RTL and testbench
========================================

Name: pipelined_block_adder

Overview:
- Parametrised, pipelined successor of the fixed 32-bit block-ripple adder.
- WIDTH-bit operands are split into BLOCK-bit ripple blocks. Each block is evaluated in its own pipeline stage, carrying registered carry between stages.
- Per-transaction mode selects the exact sum or the approximate sum. The approximate sum uses a speculative per-block carry-in, and an error flag reports whether it differs from the exact sum.
- valid/ready handshake on both sides; sits between operand sources and result consumers in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- BLOCK, 6, ripple block size in bits (1..WIDTH).
- NSTAGE, derived = ceil(WIDTH/BLOCK), pipeline depth; last block is partial when WIDTH%BLOCK != 0 (32/6: blocks 6,6,6,6,6,2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  block accepts the transaction this cycle
- in_x  in  WIDTH  operand x
- in_y  in  WIDTH  operand y
- in_mode  in  1  0 = exact, 1 = approximate
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH+1  sum; MSB is carry-out
- out_err  out  1  approximate result differs from exact; always 0 in exact mode
- out_mode  out  1  mode tag of the result

Behaviour:
- Reset: one clock with rst=1 clears all stage valid bits and zeroes all stage registers.
  - Next cycle: out_valid=0, out_sum=0, out_err=0, out_mode=0, in_ready=1.
  - Applies mid-operation: in-flight transactions are discarded and never emerge.
- Advance: adv = !valid[NSTAGE-1] || out_ready. All stages shift together when adv=1 and hold when adv=0.
  - in_ready = adv (combinational).
  - A transaction is accepted when in_valid && in_ready.
  - Bubbles propagate as valid=0.
  - Full throughput is 1 result/cycle.
- Latency: accepted on edge N, so out_valid=1 after edge N+NSTAGE-1, i.e. NSTAGE register stages when there is no stall. Latency is fixed and mode-independent, so order is always preserved.
- Stage k (0..NSTAGE-1) computes block k (bits kB..min(kB+B,WIDTH)-1).
  - Not-yet-used upper operand bits ride along in the stage registers; completed sum bits are carried forward.
  - Stage k registers: exact carry ce_k, approximate-path carry, err accumulator, mode, valid.
- Exact carry chain: cin_exact(0)=0; cin_exact(k) = carry-out of block k-1 computed with cin_exact(k-1).
- Approximate carry-in: for k>=1, cin_apx(k) = x[kB-1] & y[kB-1] (generate of the top bit of the previous block); cin_apx(0)=0.
- Sum bits of block k use cin_exact(k) when mode=0 and cin_apx(k) when mode=1.
  - Both carry chains are always computed.
- out_sum[WIDTH]:
  - mode=0: carry-out of the last block using the exact cin.
  - mode=1: carry-out of the last block using the approximate cin.
- out_err = mode && OR over k>=1 of (cin_apx(k) != cin_exact(k)). Any mismatch changes that block's sum bits, so the flag is exact.
- Stall with out_valid=1: out_sum, out_err and out_mode hold stable until out_ready=1.
- Simultaneous accept and emit when the pipe is full and out_ready=1 is legal; no bubble is inserted.
- Degenerate cases:
  - BLOCK >= WIDTH gives NSTAGE=1: a registered single-block adder with out_err always 0.
  - BLOCK=1 gives NSTAGE=WIDTH.
- Arithmetic is unsigned; no overflow other than the carry-out bit.

Decomposition:
- Shared package arith_pkg:
  - function nstage(WIDTH,BLOCK);
  - localparam MODE_EXACT=1'b0, MODE_APX=1'b1;
  - stage register struct/typedef (x_rem, y_rem, sum_acc, ce, ca, err, mode, valid).
- Sub-module adder_block (parametrised BLOCK-bit ripple of full-adder cells; inputs a, b, cin; outputs s, cout).
  - Instantiated twice per stage: once on the exact cin, once on the approximate cin.
  - The final partial block instantiates it at width WIDTH-(NSTAGE-1)*BLOCK.

Test Plan:
- WIDTH=32,BLOCK=6, mode=0, x=0xFFFFFFFF, y=0x00000001, out_ready=1 -> out_sum=0x1_00000000, out_err=0, out_valid exactly 6 cycles after acceptance.
- Same operands, mode=1 -> out_sum=0x0_FFFFFFC0, out_err=1, out_mode=1.
- mode=1, x=0x00000020, y=0x00000020 -> out_sum=0x0_00000040, out_err=0 (speculated carry matches exact).
- 10 back-to-back random transactions with mixed modes; out_ready=0 for 3 cycles mid-stream -> in_ready drops once the pipe is full; all 10 results are emitted in order with no loss or duplication; each result matches the golden exact/approx model; out_sum is stable during the stall.
- 3 transactions in flight, rst=1 for one cycle -> next cycle out_valid=0, in_ready=1, out_sum=0; none of the 3 results ever appears.
- WIDTH=8, BLOCK=4, mode=0, x=0xFF, y=0x01 -> out_sum=0x100 after 2 cycles; mode=1 -> out_sum=0x0F0, out_err=1.

Source files
------------

// File: rtl/pipelined_block_adder_pkg.sv
// Shared arithmetic definitions: mode encodings, pipeline depth helper and per-stage control fields.
// Operand-width-dependent fields are added to the stage register by the adder itself.
package arith_pkg;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_APX   = 1'b1;

  typedef struct packed {
    logic ce;     // exact carry out of the block just evaluated
    logic ca;     // carry out of the same block on the speculative carry-in
    logic err;    // sticky: some speculative carry-in missed so far
    logic mode;
    logic valid;
  } stage_ctl_t;

  function automatic int nstage(input int width, input int block);
    return (width + block - 1) / block;
  endfunction

endpackage

// File: rtl/pipelined_block_adder_if.sv
// Operand/result handshake bundle; slave is the adder side, master the source/consumer side.
interface pipelined_block_adder_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_err;
  logic             out_mode;

  modport master (
    output in_valid, in_x, in_y, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_err, out_mode
  );

  modport slave (
    input  in_valid, in_x, in_y, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_err, out_mode
  );

endinterface

// File: rtl/pipelined_block_adder_block.sv
// BLOCK-bit ripple-carry adder built from full-adder cells; purely combinational.
module adder_block #(parameter int BLOCK = 6) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout
);

  logic [BLOCK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < BLOCK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[BLOCK];

endmodule

// File: rtl/pipelined_block_adder.sv
// Pipelined block adder: one ripple block per stage, NSTAGE-cycle fixed latency, exact or speculative sum.
// All stages advance together; a stalled full output freezes the whole pipe and deasserts in_ready.
module pipelined_block_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_block_adder_if.slave bus
);

  localparam int NSTAGE = nstage(WIDTH, BLOCK);

  typedef struct packed {
    logic [WIDTH-1:0] x_rem;
    logic [WIDTH-1:0] y_rem;
    logic [WIDTH-1:0] sum_acc;
    stage_ctl_t       ctl;
  } stage_t;

  stage_t src [NSTAGE];
  stage_t nxt [NSTAGE];
  stage_t st  [NSTAGE];
  logic   adv;

  assign adv          = !st[NSTAGE-1].ctl.valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    src[0]           = '0;
    src[0].x_rem     = bus.in_x;
    src[0].y_rem     = bus.in_y;
    src[0].ctl.mode  = bus.in_mode;
    src[0].ctl.valid = bus.in_valid;
    for (int k = 1; k < NSTAGE; k++) begin
      src[k] = st[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO = k * BLOCK;
    localparam int W  = (WIDTH - LO < BLOCK) ? (WIDTH - LO) : BLOCK;

    logic [W-1:0] s_e;
    logic [W-1:0] s_a;
    logic         co_e;
    logic         co_a;
    logic         cin_e;
    logic         cin_a;
    stage_t       nxt_k;

    if (k == 0) begin : g_first
      assign cin_e = 1'b0;
      assign cin_a = 1'b0;
    end else begin : g_rest
      assign cin_e = src[k].ctl.ce;
      // Speculate the carry from the generate of the previous block's top bit.
      assign cin_a = src[k].x_rem[LO-1] & src[k].y_rem[LO-1];
    end

    adder_block #(.BLOCK(W)) u_exact (
      .a    (src[k].x_rem[LO +: W]),
      .b    (src[k].y_rem[LO +: W]),
      .cin  (cin_e),
      .s    (s_e),
      .cout (co_e)
    );

    adder_block #(.BLOCK(W)) u_apx (
      .a    (src[k].x_rem[LO +: W]),
      .b    (src[k].y_rem[LO +: W]),
      .cin  (cin_a),
      .s    (s_a),
      .cout (co_a)
    );

    always_comb begin
      nxt_k                   = src[k];
      nxt_k.sum_acc[LO +: W]  = (src[k].ctl.mode == MODE_EXACT) ? s_e : s_a;
      nxt_k.ctl.ce            = co_e;
      nxt_k.ctl.ca            = co_a;
      nxt_k.ctl.err           = src[k].ctl.err |
                                ((src[k].ctl.mode == MODE_APX) & (cin_a ^ cin_e));
    end

    assign nxt[k] = nxt_k;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        st[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NSTAGE; k++) begin
        st[k] <= nxt[k];
      end
    end
  end

  assign bus.out_valid = st[NSTAGE-1].ctl.valid;
  assign bus.out_sum   = {(st[NSTAGE-1].ctl.mode == MODE_EXACT) ? st[NSTAGE-1].ctl.ce
                                                                : st[NSTAGE-1].ctl.ca,
                          st[NSTAGE-1].sum_acc};
  assign bus.out_err   = st[NSTAGE-1].ctl.err;
  assign bus.out_mode  = st[NSTAGE-1].ctl.mode;

endmodule

// File: tb/tb_pipelined_block_adder.sv
// Self-checking bench: 32/6 and 8/4 adders against a block-arithmetic reference model.
module tb_pipelined_block_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_block_adder_if #(.WIDTH(32)) if32 ();
  pipelined_block_adder_if #(.WIDTH(8))  if8  ();

  pipelined_block_adder #(.WIDTH(32), .BLOCK(6)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  pipelined_block_adder #(.WIDTH(8),  .BLOCK(4)) dut8  (.clk(clk), .rst(rst), .bus(if8));

  // Reference: carry into bit lo is the overflow of the low lo bits added as plain integers.
  function automatic void model(input int w, input int b, input logic [31:0] x, input logic [31:0] y,
                                input logic mode, output logic [32:0] s, output logic e);
    longint unsigned xs = 64'(x);
    longint unsigned ys = 64'(y);
    longint unsigned sum = 0;
    longint unsigned cout = 0;
    e = 1'b0;
    for (int lo = 0; lo < w; lo += b) begin
      int hw = (w - lo < b) ? (w - lo) : b;
      longint unsigned lmask = (64'd1 << lo) - 1;
      longint unsigned bmask = (64'd1 << hw) - 1;
      longint unsigned cex = ((xs & lmask) + (ys & lmask)) >> lo;
      longint unsigned cap = (lo == 0) ? 0 : (((xs >> (lo - 1)) & 1) & ((ys >> (lo - 1)) & 1));
      longint unsigned cin = mode ? cap : cex;
      longint unsigned blk;
      if (lo > 0 && mode && cap != cex) e = 1'b1;
      blk  = ((xs >> lo) & bmask) + ((ys >> lo) & bmask) + cin;
      sum  = sum | ((blk & bmask) << lo);
      cout = blk >> hw;
    end
    s = 33'(sum | (cout << w));
  endfunction

  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic mode,
                       output logic [32:0] s, output logic e, output logic m, output int lat);
    @(negedge clk);
    if32.in_valid = 1'b1; if32.in_x = x; if32.in_y = y; if32.in_mode = mode; if32.out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if32.in_valid = 1'b0;
    while (!if32.out_valid && lat < 50) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!if32.out_valid) lat = -1;
    s = if32.out_sum; e = if32.out_err; m = if32.out_mode;
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic mode,
                      output logic [8:0] s, output logic e, output int lat);
    @(negedge clk);
    if8.in_valid = 1'b1; if8.in_x = x; if8.in_y = y; if8.in_mode = mode; if8.out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    while (!if8.out_valid && lat < 50) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!if8.out_valid) lat = -1;
    s = if8.out_sum; e = if8.out_err;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; if32.out_ready = 1'b0; if8.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid32 got %b expected 0", if32.out_valid); end
    n_tests++; if (if32.out_sum !== 33'd0) begin n_fail++; $display("FAIL reset_sum32 got %h expected 0", if32.out_sum); end
    n_tests++; if ({if32.out_err, if32.out_mode} !== 2'b00) begin n_fail++; $display("FAIL reset_errmode32 got %b expected 00", {if32.out_err, if32.out_mode}); end
    n_tests++; if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready32 got %b expected 1", if32.in_ready); end
    n_tests++; if ({if8.out_valid, if8.in_ready, if8.out_sum} !== {2'b01, 9'd0}) begin n_fail++; $display("FAIL reset_8 got %b/%b/%h expected 0/1/000", if8.out_valid, if8.in_ready, if8.out_sum); end
  endtask

  task automatic test_exact_carry;
    logic [32:0] s; logic e, m; int lat;
    run32(32'hFFFF_FFFF, 32'h1, 1'b0, s, e, m, lat);
    n_tests++; if (s !== 33'h1_0000_0000) begin n_fail++; $display("FAIL exact_sum got %h expected 100000000", s); end
    n_tests++; if ({e, m} !== 2'b00) begin n_fail++; $display("FAIL exact_errmode got %b expected 00", {e, m}); end
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL exact_latency got %0d expected 6", lat); end
  endtask

  task automatic test_apx_err;
    logic [32:0] s; logic e, m; int lat;
    run32(32'hFFFF_FFFF, 32'h1, 1'b1, s, e, m, lat);
    n_tests++; if (s !== 33'h0_FFFF_FFC0) begin n_fail++; $display("FAIL apx_sum got %h expected 0ffffffc0", s); end
    n_tests++; if ({e, m} !== 2'b11) begin n_fail++; $display("FAIL apx_errmode got %b expected 11", {e, m}); end
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL apx_latency got %0d expected 6", lat); end
  endtask

  task automatic test_apx_match;
    logic [32:0] s; logic e, m; int lat;
    run32(32'h20, 32'h20, 1'b1, s, e, m, lat);
    n_tests++; if ({s, e} !== {33'h40, 1'b0}) begin n_fail++; $display("FAIL apx_match got %h/%b expected 40/0", s, e); end
  endtask

  task automatic test_small_width;
    logic [8:0] s; logic e; int lat;
    run8(8'hFF, 8'h01, 1'b0, s, e, lat);
    n_tests++; if ({s, e} !== {9'h100, 1'b0}) begin n_fail++; $display("FAIL small_exact got %h/%b expected 100/0", s, e); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL small_latency got %0d expected 2", lat); end
    run8(8'hFF, 8'h01, 1'b1, s, e, lat);
    n_tests++; if ({s, e} !== {9'h0F0, 1'b1}) begin n_fail++; $display("FAIL small_apx got %h/%b expected 0f0/1", s, e); end
    for (int i = 0; i < 4; i++) begin
      logic [32:0] es; logic ee; logic [7:0] x, y; logic md;
      x = 8'($urandom); y = 8'($urandom); md = 1'($urandom);
      model(8, 4, {24'd0, x}, {24'd0, y}, md, es, ee);
      run8(x, y, md, s, e, lat);
      n_tests++; if ({s, e} !== {es[8:0], ee}) begin n_fail++; $display("FAIL small_rand x=%h y=%h m=%b got %h/%b expected %h/%b", x, y, md, s, e, es[8:0], ee); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] xs[10], ys[10]; logic ms[10];
    logic [32:0] exp_s[$]; logic exp_e[$]; logic exp_m[$];
    logic [32:0] es, held; logic ee;
    int sent = 0, got = 0, cyc = 0, idx = 0;
    bit holding = 0, saw_block = 0;
    for (int i = 0; i < 10; i++) begin
      xs[i] = $urandom; ys[i] = $urandom; ms[i] = (i < 2) ? 1'(i) : 1'($urandom);
    end
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      if32.out_ready = !(cyc >= 6 && cyc < 9);
      if32.in_valid  = (sent < 10);
      if (sent < 10) begin if32.in_x = xs[sent]; if32.in_y = ys[sent]; if32.in_mode = ms[sent]; end
      #1;
      if (!if32.out_ready && if32.out_valid) begin
        if (holding) begin
          n_tests++; if (if32.out_sum !== held) begin n_fail++; $display("FAIL stall_stable got %h expected %h", if32.out_sum, held); end
        end
        held = if32.out_sum; holding = 1;
        saw_block = 1;
        n_tests++; if (if32.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b expected 0", if32.in_ready); end
      end else begin
        holding = 0;
      end
      if (if32.out_valid && if32.out_ready) begin
        if (exp_s.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL b2b_extra got result %h expected none", if32.out_sum);
        end else begin
          es = exp_s.pop_front(); ee = exp_e.pop_front();
          n_tests++;
          if ({if32.out_sum, if32.out_err, if32.out_mode} !== {es, ee, exp_m.pop_front()}) begin
            n_fail++; $display("FAIL b2b_result[%0d] got %h/%b/%b expected %h/%b", idx, if32.out_sum, if32.out_err, if32.out_mode, es, ee);
          end
        end
        got++; idx++;
      end
      if (if32.in_valid && if32.in_ready) begin
        model(32, 6, xs[sent], ys[sent], ms[sent], es, ee);
        exp_s.push_back(es); exp_e.push_back(ee); exp_m.push_back(ms[sent]);
        sent++;
      end
      cyc++;
    end
    n_tests++; if (got !== 10) begin n_fail++; $display("FAIL b2b_count got %0d expected 10", got); end
    n_tests++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL b2b_backpressure got %b expected 1", saw_block); end
    @(negedge clk);
    if32.in_valid = 1'b0; if32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dup got valid %b expected 0", if32.out_valid); end
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    if32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if32.in_valid = 1'b1; if32.in_x = $urandom; if32.in_y = $urandom; if32.in_mode = 1'(i);
      @(negedge clk);
    end
    if32.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; if32.out_ready = 1'b0;
    #1;
    n_tests++; if ({if32.out_valid, if32.in_ready} !== 2'b01) begin n_fail++; $display("FAIL midrst_hs got %b expected 01", {if32.out_valid, if32.in_ready}); end
    n_tests++; if (if32.out_sum !== 33'd0) begin n_fail++; $display("FAIL midrst_sum got %h expected 0", if32.out_sum); end
    if32.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost got valid %b expected 0", if32.out_valid); end
    end
  endtask

  initial begin
    if32.in_valid = 1'b0; if32.in_x = '0; if32.in_y = '0; if32.in_mode = 1'b0; if32.out_ready = 1'b0;
    if8.in_valid  = 1'b0; if8.in_x  = '0; if8.in_y  = '0; if8.in_mode  = 1'b0; if8.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    test_reset;
    test_exact_carry;
    test_apx_err;
    test_apx_match;
    test_small_width;
    test_back_to_back;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
